// File: rtl/sha_sched.sv
//------------------------------------------------------------------------------
// Module   : sha_sched
// Brief    : Round-robin scheduler sharing one padder + SHA compression core
//            between NREQ requesters. Optional watchdog: SHA_SCHED_TIMEOUT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sha_sched #(
    parameter int NREQ = 4,
    parameter int BW   = 8,
    parameter int TMO  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*BW-1:0] req_nblk,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic              busy,
    output logic              pad_enable,
    output logic              pad_function,
    input  logic              pad_ready,
    output logic              hash_start,
    output logic              hash_init,
    input  logic              hash_done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0]   c_nreq_w  = (IW+1)'(NREQ);
    localparam logic [IW-1:0] c_last_rst = IW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PAD   = 3'd1,
        S_WPAD  = 3'd2,
        S_HASH  = 3'd3,
        S_WHASH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   w_pick;
    logic            w_found;
    logic [IW:0]     w_idx;

    logic [BW-1:0]   r_nblk;
    logic [BW-1:0]   r_blk_cnt;
    logic            r_first;
    logic [BW:0]     w_cnt_inc;
    logic            w_last_blk;
    logic            w_timeout;
    logic [NREQ-1:0] w_owner_oh;

    logic [BW-1:0]   w_nblk_arr [NREQ];

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_unpack
            assign w_nblk_arr[g] = req_nblk[g*BW +: BW];
        end
    endgenerate

    // Rotating-priority search: start just after the previous owner and wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = {1'b0, r_last} + (IW+1)'(i);
            if (w_idx >= c_nreq_w) begin
                w_idx = w_idx - c_nreq_w;
            end
            if (!w_found && req[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[IW-1:0];
            end
        end
    end

    // One extra bit so nblk = 2^BW-1 compares before the counter could wrap.
    assign w_cnt_inc  = {1'b0, r_blk_cnt} + (BW+1)'(1);
    assign w_last_blk = (w_cnt_inc == {1'b0, r_nblk});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        pad_enable   = 1'b0;
        pad_function = 1'b0;
        hash_start   = 1'b0;
        hash_init    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_PAD;
                end
            end
            S_PAD: begin
                pad_enable   = 1'b1;
                pad_function = ~r_first;
                w_next       = S_WPAD;
            end
            S_WPAD: begin
                if (pad_ready) begin
                    w_next = S_HASH;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_HASH: begin
                hash_start = 1'b1;
                hash_init  = r_first;
                w_next     = S_WHASH;
            end
            S_WHASH: begin
                if (hash_done) begin
                    w_next = w_last_blk ? S_DONE : S_PAD;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner   <= '0;
            r_last    <= c_last_rst;
            r_nblk    <= '0;
            r_blk_cnt <= '0;
            r_first   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner   <= w_pick;
                        r_nblk    <= (w_nblk_arr[w_pick] == '0) ? BW'(1) : w_nblk_arr[w_pick];
                        r_blk_cnt <= '0;
                        r_first   <= 1'b1;
                    end
                end
                S_HASH: begin
                    r_first <= 1'b0;
                end
                S_WHASH: begin
                    if (hash_done) begin
                        r_blk_cnt <= w_cnt_inc[BW-1:0];
                    end
                end
                S_DONE: begin
                    r_last <= r_owner;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
    assign grant      = (r_state != S_IDLE) ? w_owner_oh : '0;
    assign ack        = (r_state == S_DONE) ? w_owner_oh : '0;
    assign busy       = (r_state != S_IDLE);

`ifdef SHA_SCHED_TIMEOUT_EN
    localparam int WW = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [WW-1:0] c_wd_last = WW'(TMO - 1);

    logic [WW-1:0] r_wd;
    logic          r_err;

    assign w_timeout = (r_wd == c_wd_last);

    // Counter sits at zero outside the wait states, so every wait starts from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_WPAD || r_state == S_WHASH) begin
                r_wd <= r_wd + WW'(1);
            end else begin
                r_wd <= '0;
            end
            r_err <= w_timeout &&
                     ((r_state == S_WPAD && !pad_ready) ||
                      (r_state == S_WHASH && !hash_done));
        end
    end

    assign err = r_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TMO > 0);
    assign w_timeout    = 1'b0;
    assign err          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sha_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_sha_sched
// Brief    : Scoreboard bench for sha_sched; padder/core modelled as responders.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sha_sched;

    localparam int NREQ = 4;
    localparam int BW   = 8;
    localparam int K_PAD  = 1;
    localparam int K_HASH = 2;
    localparam int K_ACK  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*BW-1:0] req_nblk;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic              busy;
    logic              pad_enable;
    logic              pad_function;
    logic              pad_ready;
    logic              hash_start;
    logic              hash_init;
    logic              hash_done;

    logic              hash_mute;
    int                total = 0;
    int                bad   = 0;
    int                hs_cnt = 0;
    logic [NREQ-1:0]   prev_ack = '0;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } exp_t;
    exp_t sbq[$];

    sha_sched #(.NREQ(NREQ), .BW(BW), .TMO(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_nblk     (req_nblk),
        .grant        (grant),
        .ack          (ack),
        .err          (err),
        .busy         (busy),
        .pad_enable   (pad_enable),
        .pad_function (pad_function),
        .pad_ready    (pad_ready),
        .hash_start   (hash_start),
        .hash_init    (hash_init),
        .hash_done    (hash_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [NREQ-1:0] g, input logic b);
        exp_t e;
        e.kind = k;
        e.val  = {3'b000, g, b};
        sbq.push_back(e);
    endtask

    task automatic push_txn(input int own, input int n);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << own;
        for (int b = 0; b < n; b++) begin
            push(K_PAD,  oh, b != 0);
            push(K_HASH, oh, b == 0);
        end
        push(K_ACK, oh, 1'b0);
    endtask

    task automatic sb_check(input int k, input logic [7:0] v, input string nm);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event kind=%0d val=%0h, nothing pending", nm, k, v);
        end else begin
            e = sbq.pop_front();
            if (e.kind != k || e.val !== v) begin
                bad++;
                $display("FAIL %s: got kind=%0d val=%0h expected kind=%0d val=%0h",
                         nm, k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: every DUT-presented event is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (pad_enable) sb_check(K_PAD, {3'b000, grant, pad_function}, "pad");
            if (hash_start) begin
                hs_cnt++;
                sb_check(K_HASH, {3'b000, grant, hash_init}, "hash");
            end
            if (ack != '0) begin
                chk("ack_one_cycle", 32'(prev_ack), 32'd0);
                sb_check(K_ACK, {3'b000, ack, err}, "ack");
            end
            if (err && ack == '0) chk("err_without_ack", 32'(err), 32'd0);
            prev_ack = ack;
        end else begin
            prev_ack = '0;
        end
    end

    // Padder model: pad_ready arrives on the second WPAD cycle.
    initial begin
        pad_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (pad_enable) begin
                @(posedge clk);
                @(posedge clk);
                #1 pad_ready = 1'b1;
                @(posedge clk);
                #1 pad_ready = 1'b0;
            end
        end
    end

    // Core model: hash_done arrives on the second WHASH cycle unless muted.
    initial begin
        hash_done = 1'b0;
        forever begin
            @(negedge clk);
            if (hash_start && !hash_mute) begin
                @(posedge clk);
                @(posedge clk);
                #1 hash_done = 1'b1;
                @(posedge clk);
                #1 hash_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_ack(output int cyc, input int bound);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ack == '0 && cyc < bound);
        if (ack == '0) chk("ack_wait_expired", 32'(ack), 32'hFFFF_FFFF);
    endtask

    task automatic wait_hash_start(input int bound);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!hash_start && c < bound);
        if (!hash_start) chk("hash_start_wait_expired", 32'(hash_start), 32'd1);
    endtask

    initial begin
        int cyc;
        int hs0;
        rst       = 1'b0;
        req       = '0;
        req_nblk  = '0;
        hash_mute = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {grant, ack, err, busy, pad_enable, pad_function, hash_start, hash_init}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single block on requester 0, latency from sampling edge to ack
        req_nblk[0 +: BW] = 8'd1;
        push_txn(0, 1);
        hs0 = hs_cnt;
        req = 4'b0001;
        @(posedge clk);
        wait_ack(cyc, 100);
        chk("t1_latency", cyc, 7);
        req = '0;
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_hash_starts", hs_cnt - hs0, 1);

        // Three blocks on requester 1
        req_nblk[BW +: BW] = 8'd3;
        push_txn(1, 3);
        hs0 = hs_cnt;
        req = 4'b0010;
        wait_ack(cyc, 200);
        req = '0;
        @(negedge clk);
        chk("t2_hash_starts", hs_cnt - hs0, 3);
        chk("t2_busy_after", 32'(busy), 32'd0);

        // All requesting, fresh priority: 0,1,2,3,0
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) req_nblk[i*BW +: BW] = 8'd1;
        push_txn(0, 1);
        push_txn(1, 1);
        push_txn(2, 1);
        push_txn(3, 1);
        push_txn(0, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_ack(cyc, 100);
        req = '0;
        @(negedge clk);
        chk("t3_busy_after", 32'(busy), 32'd0);

        // nblk = 0 behaves as one block
        req_nblk[2*BW +: BW] = 8'd0;
        push_txn(2, 1);
        hs0 = hs_cnt;
        req = 4'b0100;
        wait_ack(cyc, 100);
        req = '0;
        @(negedge clk);
        chk("t4_hash_starts", hs_cnt - hs0, 1);

        // Reset during WHASH of a 3-block job on requester 1
        req_nblk[BW +: BW] = 8'd3;
        push(K_PAD,  4'b0010, 1'b0);
        push(K_HASH, 4'b0010, 1'b1);
        req = 4'b0010;
        wait_hash_start(100);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t5_outputs_in_reset", {grant, ack, err, busy, pad_enable, pad_function, hash_start, hash_init}, 32'd0);
        chk("t5_sb_drained", sbq.size(), 0);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        // With last_grant reinitialised requester 1 beats 3
        req_nblk[BW +: BW]   = 8'd1;
        req_nblk[3*BW +: BW] = 8'd1;
        push_txn(1, 1);
        req = 4'b1010;
        @(negedge clk);
        req = '0;
        wait_ack(cyc, 100);
        @(negedge clk);
        chk("t5_busy_after", 32'(busy), 32'd0);

`ifdef SHA_SCHED_TIMEOUT_EN
        // Core never answers: 16 waiting cycles then ack with err
        hash_mute = 1'b1;
        req_nblk[0 +: BW] = 8'd1;
        push(K_PAD,  4'b0001, 1'b0);
        push(K_HASH, 4'b0001, 1'b1);
        push(K_ACK,  4'b0001, 1'b1);
        req = 4'b0001;
        wait_hash_start(100);
        req = '0;
        wait_ack(cyc, 100);
        chk("t6_wait_cycles", cyc, 17);
        @(negedge clk);
        chk("t6_busy_after", 32'(busy), 32'd0);
        hash_mute = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty_at_end", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
